// File: rtl/mdu_pkg.sv
// mdu_pkg: opcodes, FSM state encodings and shared helpers for the multiply/divide unit.
// Revision 1.0
`default_nettype none

package mdu_pkg;

  localparam int MDU_ITER  = 32;
  localparam int MDU_CNT_W = 6;

  typedef enum logic [1:0] {
    MDU_OP_MULT  = 2'd0,
    MDU_OP_MULTU = 2'd1,
    MDU_OP_DIV   = 2'd2,
    MDU_OP_DIVU  = 2'd3
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_ST_IDLE = 2'd0,
    MDU_ST_RUN  = 2'd1,
    MDU_ST_FIN  = 2'd2
  } mdu_state_e;

  function automatic logic op_is_div(input mdu_op_e op);
    return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input mdu_op_e op);
    return (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division step (shift in a dividend bit, trial subtract).
// Revision 1.0
`default_nettype none

module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] div_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;

  assign shifted = {rem_i, bit_i};
  assign q_o     = (shifted >= {1'b0, div_i});
  // On a successful subtract the result is below the divisor, so the low WIDTH bits are exact.
  assign rem_o   = q_o ? (shifted[WIDTH-1:0] - div_i) : shifted[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/mdu.sv
// mdu: multi-cycle MULT/MULTU/DIV/DIVU unit writing HI/LO, with MTHI/MTLO write ports.
// Divider datapath compiled only when MDU_DIV_EN is defined. Revision 1.0
`default_nettype none

module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e           state_q, state_d;
  logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
  mdu_op_e              op_q, op_d;
  logic                 sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;

  mdu_op_e          op_in;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign op_in  = mdu_op_e'(op);
  assign sign_a = op_is_signed(op_in) & a[WIDTH-1];
  assign sign_b = op_is_signed(op_in) & b[WIDTH-1];
  assign mag_a  = sign_a ? -a : a;
  assign mag_b  = sign_b ? -b : b;

  // Shift-add: multiplier sits in the low half and is consumed LSB first.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, prod_fix;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;

`ifdef MDU_DIV_EN
  logic               divz_q, divz_d;
  logic [WIDTH-1:0]   rem_nx, quo_fix, rem_fix;
  logic               q_bit;
  logic [2*WIDTH-1:0] div_next;

  // Remainder in the high half, dividend shifting out / quotient shifting in at the low half.
  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i (acc_q[2*WIDTH-1:WIDTH]),
    .div_i (opnd_q),
    .bit_i (acc_q[WIDTH-1]),
    .rem_o (rem_nx),
    .q_o   (q_bit)
  );

  assign div_next = {rem_nx, acc_q[WIDTH-2:0], q_bit};
  assign quo_fix  = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
`ifdef MDU_DIV_EN
    divz_d  = divz_q;
`endif
    case (state_q)
      MDU_ST_IDLE: begin
        if (start) begin
          op_d    = op_in;
          sa_d    = sign_a;
          sb_d    = sign_b;
          cnt_d   = '0;
          state_d = MDU_ST_RUN;
          if (op_is_div(op_in)) begin
            opnd_d = mag_b;
            acc_d  = {{WIDTH{1'b0}}, mag_a};
          end else begin
            opnd_d = mag_a;
            acc_d  = {{WIDTH{1'b0}}, mag_b};
          end
`ifdef MDU_DIV_EN
          divz_d = 1'b0;
          if (op_is_div(op_in) && (b == '0)) begin
            divz_d  = 1'b1;
            acc_d   = {a, {WIDTH{1'b1}}};
            state_d = MDU_ST_FIN;
          end
`else
          if (op_is_div(op_in)) begin
            state_d = MDU_ST_FIN;
          end
`endif
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      MDU_ST_RUN: begin
`ifdef MDU_DIV_EN
        acc_d = op_is_div(op_q) ? div_next : mul_next;
`else
        acc_d = mul_next;
`endif
        cnt_d = cnt_q + MDU_CNT_W'(1);
        if (cnt_q == MDU_CNT_W'(MDU_ITER - 1)) state_d = MDU_ST_FIN;
      end
      MDU_ST_FIN: begin
        done_d  = 1'b1;
        state_d = MDU_ST_IDLE;
        if (!op_is_div(op_q)) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
`ifdef MDU_DIV_EN
        else if (divz_q) begin
          hi_d = acc_q[2*WIDTH-1:WIDTH];
          lo_d = acc_q[WIDTH-1:0];
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
`endif
      end
      default: state_d = MDU_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MDU_ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MDU_OP_MULT;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
`ifdef MDU_DIV_EN
      divz_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
`ifdef MDU_DIV_EN
      divz_q  <= divz_d;
`endif
    end
  end

  assign busy = (state_q != MDU_ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

`default_nettype wire
